// File: rtl/tdm_defs.sv
// rtl/tdm_defs.sv - shared FSM encoding, slot constants and defaults for the TDM demux
package tdm_defs;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } tdm_state_e;

    localparam logic [1:0] SLOT0 = 2'd0;
    localparam logic [1:0] SLOT1 = 2'd1;
    localparam logic [1:0] SLOT2 = 2'd2;
    localparam logic [1:0] SLOT3 = 2'd3;

    localparam int SYNC_LOSS_DEFAULT = 2;

endpackage

// File: rtl/tdm_slot_ctr.sv
// rtl/tdm_slot_ctr.sv - 2-bit slot counter with clear/restart/increment and 1-of-4 slot decode
module tdm_slot_ctr
    import tdm_defs::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       restart,
    input  logic       inc,
    output logic [1:0] slot,
    output logic [3:0] slot_we
);

    logic [1:0] slot_q;
    logic [1:0] slot_d;

    // restart means "slot 0 was just taken", so the next expected slot is 1
    always_comb begin
        slot_d = slot_q;
        if (clr) begin
            slot_d = SLOT0;
        end else if (restart) begin
            slot_d = SLOT1;
        end else if (inc) begin
            slot_d = slot_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q <= SLOT0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot    = slot_q;
    assign slot_we = 4'b0001 << slot_q;

endmodule

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 4-channel TDM receive demux with flywheel frame lock and atomic frame update
module tdm_demux4
    import tdm_defs::*;
#(
    parameter int W         = 1,
    parameter int SYNC_LOSS = SYNC_LOSS_DEFAULT
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    input  logic         fsync,
    output logic [W-1:0] t0,
    output logic [W-1:0] t1,
    output logic [W-1:0] t2,
    output logic [W-1:0] t3,
    output logic         s1,
    output logic         s0,
    output logic         frame_valid,
    output logic         locked,
    output logic         sync_err
);

    localparam logic [3:0] LOSS_LIM = 4'(SYNC_LOSS);

    tdm_state_e   state_q, state_d;
    logic [2:0]   miss_q, miss_d;
    logic [W-1:0] h0_q, h0_d;
    logic [W-1:0] h1_q, h1_d;
    logic [W-1:0] h2_q, h2_d;
    logic [W-1:0] t0_q, t0_d;
    logic [W-1:0] t1_q, t1_d;
    logic [W-1:0] t2_q, t2_d;
    logic [W-1:0] t3_q, t3_d;
    logic         fv_q, fv_d;
    logic         err_q, err_d;

    logic         slot_clr;
    logic         slot_restart;
    logic         slot_inc;
    logic [1:0]   slot;
    logic [3:0]   slot_we;
    logic [3:0]   miss_inc;

    tdm_slot_ctr u_slot_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (slot_clr),
        .restart (slot_restart),
        .inc     (slot_inc),
        .slot    (slot),
        .slot_we (slot_we)
    );

    assign miss_inc = {1'b0, miss_q} + 4'd1;

    always_comb begin
        state_d      = state_q;
        miss_d       = miss_q;
        h0_d         = h0_q;
        h1_d         = h1_q;
        h2_d         = h2_q;
        t0_d         = t0_q;
        t1_d         = t1_q;
        t2_d         = t2_q;
        t3_d         = t3_q;
        fv_d         = 1'b0;
        err_d        = 1'b0;
        slot_clr     = 1'b0;
        slot_restart = 1'b0;
        slot_inc     = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (fsync) begin
                        h0_d         = din;
                        slot_restart = 1'b1;
                        miss_d       = 3'd0;
                        state_d      = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (fsync) begin
                        // a mark anywhere but slot 0 abandons the partial frame
                        err_d        = !slot_we[0];
                        h0_d         = din;
                        slot_restart = 1'b1;
                        miss_d       = 3'd0;
                    end else if (slot_we[0]) begin
                        if (miss_inc < LOSS_LIM) begin
                            // flywheel: trust the slot count through a missing mark
                            h0_d         = din;
                            slot_restart = 1'b1;
                            miss_d       = miss_inc[2:0];
                        end else begin
                            state_d  = ST_HUNT;
                            err_d    = 1'b1;
                            slot_clr = 1'b1;
                            miss_d   = 3'd0;
                        end
                    end else if (slot_we[1]) begin
                        h1_d     = din;
                        slot_inc = 1'b1;
                    end else if (slot_we[2]) begin
                        h2_d     = din;
                        slot_inc = 1'b1;
                    end else if (slot_we[3]) begin
                        t0_d     = h0_q;
                        t1_d     = h1_q;
                        t2_d     = h2_q;
                        t3_d     = din;
                        fv_d     = 1'b1;
                        slot_inc = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_HUNT;
            miss_q  <= 3'd0;
            h0_q    <= '0;
            h1_q    <= '0;
            h2_q    <= '0;
            t0_q    <= '0;
            t1_q    <= '0;
            t2_q    <= '0;
            t3_q    <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
            h0_q    <= h0_d;
            h1_q    <= h1_d;
            h2_q    <= h2_d;
            t0_q    <= t0_d;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
            t3_q    <= t3_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
        end
    end

    assign t0          = t0_q;
    assign t1          = t1_q;
    assign t2          = t2_q;
    assign t3          = t3_q;
    assign s1          = slot[1];
    assign s0          = slot[0];
    assign frame_valid = fv_q;
    assign locked      = (state_q == ST_LOCKED);
    assign sync_err    = err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - table-driven self-checking bench for tdm_demux4
module tb_tdm_demux4;

    localparam int W = 4;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] din;
    logic         din_valid;
    logic         fsync;
    logic [W-1:0] t0, t1, t2, t3;
    logic         s1, s0;
    logic         frame_valid;
    logic         locked;
    logic         sync_err;

    int errors = 0;
    int checks = 0;

    tdm_demux4 #(.W(W), .SYNC_LOSS(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .din         (din),
        .din_valid   (din_valid),
        .fsync       (fsync),
        .t0          (t0),
        .t1          (t1),
        .t2          (t2),
        .t3          (t3),
        .s1          (s1),
        .s0          (s0),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic         f;
        logic [W-1:0] d;
        logic [W-1:0] e0, e1, e2, e3;
        logic         efv, elk, eerr;
        logic [1:0]   eslot;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic f, logic [W-1:0] d,
                                logic [W-1:0] e0, logic [W-1:0] e1,
                                logic [W-1:0] e2, logic [W-1:0] e3,
                                logic efv, logic elk, logic eerr, logic [1:0] eslot);
        vec_t r;
        r.v = v; r.f = f; r.d = d;
        r.e0 = e0; r.e1 = e1; r.e2 = e2; r.e3 = e3;
        r.efv = efv; r.elk = elk; r.eerr = eerr; r.eslot = eslot;
        return r;
    endfunction

    // observation bundle: t0,t1,t2,t3,frame_valid,locked,sync_err,s1s0
    function automatic logic [4*W+4:0] obs();
        return {t0, t1, t2, t3, frame_valid, locked, sync_err, s1, s0};
    endfunction

    task automatic check(string name, logic [4*W+4:0] exp_v);
        logic [4*W+4:0] got;
        got = obs();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s: got t=%h%h%h%h fv=%b lk=%b err=%b slot=%0d, want t=%h%h%h%h fv=%b lk=%b err=%b slot=%0d",
                     name, got[20:17], got[16:13], got[12:9], got[8:5], got[4], got[3], got[2], got[1:0],
                     exp_v[20:17], exp_v[16:13], exp_v[12:9], exp_v[8:5], exp_v[4], exp_v[3], exp_v[2], exp_v[1:0]);
        end
    endtask

    task automatic drive(logic v, logic f, logic [W-1:0] d);
        @(negedge clk);
        din_valid = v;
        fsync     = f;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        fsync     = 1'b0;

        //            v  f  d      t0   t1   t2   t3   fv lk er slot
        // clean lock
        vecs.push_back(mk(1, 1, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 0, 2'd1));
        vecs.push_back(mk(1, 0, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 0, 2'd2));
        vecs.push_back(mk(1, 0, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 0, 2'd3));
        vecs.push_back(mk(1, 0, 4'h7, 4'hA, 4'h5, 4'h6, 4'h7, 1, 1, 0, 2'd0));
        // same frame with gaps between samples
        vecs.push_back(mk(0, 0, 4'hF, 4'hA, 4'h5, 4'h6, 4'h7, 0, 1, 0, 2'd0));
        vecs.push_back(mk(1, 1, 4'hA, 4'hA, 4'h5, 4'h6, 4'h7, 0, 1, 0, 2'd1));
        vecs.push_back(mk(0, 1, 4'hF, 4'hA, 4'h5, 4'h6, 4'h7, 0, 1, 0, 2'd1));
        vecs.push_back(mk(1, 0, 4'h5, 4'hA, 4'h5, 4'h6, 4'h7, 0, 1, 0, 2'd2));
        vecs.push_back(mk(0, 0, 4'hF, 4'hA, 4'h5, 4'h6, 4'h7, 0, 1, 0, 2'd2));
        vecs.push_back(mk(1, 0, 4'h6, 4'hA, 4'h5, 4'h6, 4'h7, 0, 1, 0, 2'd3));
        vecs.push_back(mk(0, 0, 4'hF, 4'hA, 4'h5, 4'h6, 4'h7, 0, 1, 0, 2'd3));
        vecs.push_back(mk(1, 0, 4'h7, 4'hA, 4'h5, 4'h6, 4'h7, 1, 1, 0, 2'd0));
        vecs.push_back(mk(0, 0, 4'hF, 4'hA, 4'h5, 4'h6, 4'h7, 0, 1, 0, 2'd0));
        // early fsync abandons the partial frame 1,2
        vecs.push_back(mk(1, 1, 4'h1, 4'hA, 4'h5, 4'h6, 4'h7, 0, 1, 0, 2'd1));
        vecs.push_back(mk(1, 0, 4'h2, 4'hA, 4'h5, 4'h6, 4'h7, 0, 1, 0, 2'd2));
        vecs.push_back(mk(1, 1, 4'h9, 4'hA, 4'h5, 4'h6, 4'h7, 0, 1, 1, 2'd1));
        vecs.push_back(mk(1, 0, 4'h3, 4'hA, 4'h5, 4'h6, 4'h7, 0, 1, 0, 2'd2));
        vecs.push_back(mk(1, 0, 4'h4, 4'hA, 4'h5, 4'h6, 4'h7, 0, 1, 0, 2'd3));
        vecs.push_back(mk(1, 0, 4'h5, 4'h9, 4'h3, 4'h4, 4'h5, 1, 1, 0, 2'd0));
        // one missing mark: flywheel keeps the frame
        vecs.push_back(mk(1, 0, 4'h8, 4'h9, 4'h3, 4'h4, 4'h5, 0, 1, 0, 2'd1));
        vecs.push_back(mk(1, 0, 4'h1, 4'h9, 4'h3, 4'h4, 4'h5, 0, 1, 0, 2'd2));
        vecs.push_back(mk(1, 0, 4'h2, 4'h9, 4'h3, 4'h4, 4'h5, 0, 1, 0, 2'd3));
        vecs.push_back(mk(1, 0, 4'h3, 4'h8, 4'h1, 4'h2, 4'h3, 1, 1, 0, 2'd0));
        // second consecutive miss: sample dropped, back to hunt
        vecs.push_back(mk(1, 0, 4'hE, 4'h8, 4'h1, 4'h2, 4'h3, 0, 0, 1, 2'd0));
        vecs.push_back(mk(1, 0, 4'h6, 4'h8, 4'h1, 4'h2, 4'h3, 0, 0, 0, 2'd0));
        // relock
        vecs.push_back(mk(1, 1, 4'hD, 4'h8, 4'h1, 4'h2, 4'h3, 0, 1, 0, 2'd1));
        vecs.push_back(mk(1, 0, 4'h1, 4'h8, 4'h1, 4'h2, 4'h3, 0, 1, 0, 2'd2));
        vecs.push_back(mk(1, 0, 4'h2, 4'h8, 4'h1, 4'h2, 4'h3, 0, 1, 0, 2'd3));
        vecs.push_back(mk(1, 0, 4'h3, 4'hD, 4'h1, 4'h2, 4'h3, 1, 1, 0, 2'd0));
        // miss, then a good mark clears the miss count, then another miss flywheels
        vecs.push_back(mk(1, 0, 4'hF, 4'hD, 4'h1, 4'h2, 4'h3, 0, 1, 0, 2'd1));
        vecs.push_back(mk(1, 0, 4'h1, 4'hD, 4'h1, 4'h2, 4'h3, 0, 1, 0, 2'd2));
        vecs.push_back(mk(1, 0, 4'h2, 4'hD, 4'h1, 4'h2, 4'h3, 0, 1, 0, 2'd3));
        vecs.push_back(mk(1, 0, 4'h3, 4'hF, 4'h1, 4'h2, 4'h3, 1, 1, 0, 2'd0));
        vecs.push_back(mk(1, 1, 4'h0, 4'hF, 4'h1, 4'h2, 4'h3, 0, 1, 0, 2'd1));
        vecs.push_back(mk(1, 0, 4'h4, 4'hF, 4'h1, 4'h2, 4'h3, 0, 1, 0, 2'd2));
        vecs.push_back(mk(1, 0, 4'h5, 4'hF, 4'h1, 4'h2, 4'h3, 0, 1, 0, 2'd3));
        vecs.push_back(mk(1, 0, 4'h6, 4'h0, 4'h4, 4'h5, 4'h6, 1, 1, 0, 2'd0));
        vecs.push_back(mk(1, 0, 4'h7, 4'h0, 4'h4, 4'h5, 4'h6, 0, 1, 0, 2'd1));

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", '0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].f, vecs[i].d);
            check($sformatf("vec%0d", i),
                  {vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3,
                   vecs[i].efv, vecs[i].elk, vecs[i].eerr, vecs[i].eslot});
        end

        // asynchronous reset mid-frame: outputs clear without a clock edge
        @(negedge clk);
        #2;
        reset_n   = 1'b0;
        din_valid = 1'b0;
        #1;
        check("async_reset_immediate", '0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) drive(0, 0, 4'h0);
        check("idle_after_reset", '0);

        // reset asserted across the slot-3 acceptance edge
        drive(1, 1, 4'hA);
        drive(1, 0, 4'h5);
        drive(1, 0, 4'h6);
        check("pre_slot3", {16'h0000, 1'b0, 1'b1, 1'b0, 2'd3});
        @(negedge clk);
        din_valid = 1'b1;
        fsync     = 1'b0;
        din       = 4'h7;
        reset_n   = 1'b0;
        @(posedge clk);
        #1;
        check("reset_on_slot3", '0);
        @(negedge clk);
        #1;
        check("reset_on_slot3_after", '0);
        din_valid = 1'b0;
        reset_n   = 1'b1;

        // fresh lock after that reset needs a full frame
        drive(1, 0, 4'h7);
        check("hunt_after_reset", '0);
        drive(1, 1, 4'hC);
        drive(1, 0, 4'hB);
        drive(1, 0, 4'hA);
        drive(1, 0, 4'h9);
        check("relock_frame", {16'hCBA9, 1'b1, 1'b1, 1'b0, 2'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
